// File: rtl/sram_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_responder
// Purpose  : CPU byte-bus target backed by the DE0 256K x 16 asynchronous
//            SRAM. Reads are combinational through the SRAM; writes are
//            posted and drained in the following cycle with a half-cycle WE#.
//            Optional macro SRAM_WFWD_EN forwards the draining byte to a
//            read of the same address.
// Revision : 1.0  initial release
// ============================================================================
module sram_bus_responder #(
    parameter int         SRAM_AW  = 18,
    parameter logic [7:0] OOR_DATA = 8'hFF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [19:0]        bus_addr,
    input  logic [7:0]         bus_wdata,
    input  logic               bus_we,
    output logic [7:0]         bus_rdata,
    output logic               bus_wait,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_dq,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WR   = 1'b1;

    logic [0:0]       r_state;
    logic [SRAM_AW:0] r_wa;
    logic [7:0]       r_wd;
    logic             r_pos_tog;
    logic             r_neg_tog;

    logic             w_pend;
    logic             w_capture;
    logic             w_fwd_hit;
    logic [7:0]       w_rd_lane;

    assign w_pend    = (r_state == ST_WR);
    assign w_capture = bus_we && !bus_addr[19];

    // Both IDLE and WR move to WR on a captured write and to IDLE otherwise,
    // so the posted buffer simply reloads every edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_wa      <= '0;
            r_wd      <= '0;
            r_pos_tog <= 1'b0;
        end else begin
            r_pos_tog <= r_neg_tog;
            if (w_capture) begin
                r_state <= ST_WR;
                r_wa    <= bus_addr[SRAM_AW:0];
                r_wd    <= bus_wdata;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    // WE# is low while the two toggles differ: the negedge flop opens the
    // pulse mid-drain and the posedge flop closes it, glitch-free.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_neg_tog <= 1'b0;
        end else if (w_pend) begin
            r_neg_tog <= ~r_pos_tog;
        end
    end

    assign sram_we_n = ~(r_neg_tog ^ r_pos_tog);
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = w_pend | ~reset_n;
    assign sram_addr = w_pend ? r_wa[SRAM_AW:1] : bus_addr[SRAM_AW:1];
    assign sram_ub_n = w_pend & ~r_wa[0];
    assign sram_lb_n = w_pend &  r_wa[0];
    assign sram_dq   = w_pend ? {r_wd, r_wd} : {16{1'bz}};

    assign w_rd_lane = bus_addr[0] ? sram_dq[15:8] : sram_dq[7:0];

`ifdef SRAM_WFWD_EN
    assign w_fwd_hit = w_pend && (bus_addr[SRAM_AW:0] == r_wa);
`else
    assign w_fwd_hit = 1'b0;
`endif

    always_comb begin
        bus_rdata = w_rd_lane;
        bus_wait  = 1'b0;
        if (w_pend) begin
            bus_wait  = ~w_fwd_hit;
            bus_rdata = w_fwd_hit ? r_wd : OOR_DATA;
        end else if (bus_addr[19]) begin
            bus_rdata = OOR_DATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_responder.sv
`default_nettype none
// Testbench for sram_bus_responder: asynchronous SRAM model plus a read
// scoreboard; WE# pulse width and address/data stability are monitored.
module tb_sram_bus_responder;

    localparam int         SRAM_AW  = 18;
    localparam logic [7:0] OOR_DATA = 8'hFF;

    logic               clock     = 1'b0;
    logic               reset_n   = 1'b1;
    logic [19:0]        bus_addr  = '0;
    logic [7:0]         bus_wdata = '0;
    logic               bus_we    = 1'b0;
    logic [7:0]         bus_rdata;
    logic               bus_wait;
    logic [SRAM_AW-1:0] sram_addr;
    wire  [15:0]        sram_dq;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;
    logic               sram_ub_n;
    logic               sram_lb_n;

    logic [15:0] mem [0:(1<<SRAM_AW)-1];

    int n_checks  = 0;
    int n_errors  = 0;
    int pulse_cnt = 0;

    typedef struct {
        string      tag;
        logic [7:0] data;
        bit         chk_data;
        logic       wait_exp;
    } sb_item_t;

    sb_item_t sb[$];

    sram_bus_responder #(
        .SRAM_AW  (SRAM_AW),
        .OOR_DATA (OOR_DATA)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_rdata (bus_rdata),
        .bus_wait  (bus_wait),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

    always #20 clock = ~clock;

    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

    function automatic logic [15:0] pattern(input logic [17:0] wa);
        return {wa[7:0] ^ 8'hC3, wa[15:8] ^ 8'h5A};
    endfunction

    function automatic logic [7:0] orig_byte(input logic [19:0] a);
        logic [15:0] w;
        w = pattern(a[18:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [19:0] a, input logic w, input logic [7:0] d);
        bus_addr  = a;
        bus_we    = w;
        bus_wdata = d;
    endtask

    task automatic expect_rd(input string tag, input logic [7:0] d, input bit cd, input logic w);
        sb_item_t it;
        it.tag      = tag;
        it.data     = d;
        it.chk_data = cd;
        it.wait_exp = w;
        sb.push_back(it);
    endtask

    initial begin
        for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = pattern(18'(i));
    end

    // SRAM write model: address/data/lanes taken at the WE# fall, committed at the rise.
    time         t_fall = 0;
    logic [17:0] pa     = '0;
    logic [15:0] pd     = '0;
    logic        pub    = 1'b1;
    logic        plb    = 1'b1;

    always @(negedge sram_we_n) begin
        t_fall = $time;
        pa     = sram_addr;
        pd     = sram_dq;
        pub    = sram_ub_n;
        plb    = sram_lb_n;
        pulse_cnt++;
    end

    always @(posedge sram_we_n) begin
        if (reset_n && t_fall != 0) check("we_pulse_width", 32'($time - t_fall), 32'd20);
        if (plb === 1'b0) mem[pa][7:0]  = pd[7:0];
        if (pub === 1'b0) mem[pa][15:8] = pd[15:8];
        pub = 1'b1;
        plb = 1'b1;
    end

    // Address, data and lanes must hold from just after the fall to just before the rise.
    always @(negedge clock) begin : stab_mon
        logic [17:0] a0;
        logic [15:0] d0;
        logic [1:0]  l0;
        #1;
        if (reset_n && sram_we_n === 1'b0) begin
            a0 = sram_addr;
            d0 = sram_dq;
            l0 = {sram_ub_n, sram_lb_n};
            #17;
            check("we_addr_stable",  32'(sram_addr), 32'(a0));
            check("we_data_stable",  32'(sram_dq), 32'(d0));
            check("we_lanes_stable", 32'({sram_ub_n, sram_lb_n}), 32'(l0));
        end
    end

    always @(negedge clock) begin : sb_mon
        sb_item_t it;
        #2;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            check({it.tag, "_wait"}, 32'(bus_wait), 32'(it.wait_exp));
            if (it.chk_data) check({it.tag, "_data"}, 32'(bus_rdata), 32'(it.data));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0;
        logic [19:0] la;
        logic [7:0]  ld;

        // Reset state
        #2 reset_n = 1'b0;
        #3;
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
        check("rst_wait", 32'(bus_wait), 32'd0);
        check("rst_ub_n", 32'(sram_ub_n), 32'd0);
        check("rst_lb_n", 32'(sram_lb_n), 32'd0);
        check("rst_ce_n", 32'(sram_ce_n), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Reset asserted in a drain cycle: posted byte lost
        tick(); drive(20'h00400, 1'b1, 8'hE1); p0 = pulse_cnt;
        tick(); drive(20'h00000, 1'b0, 8'h00);
        #4 reset_n = 1'b0;
        #1;
        check("midrst_we_n", 32'(sram_we_n), 32'd1);
        check("midrst_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
        check("midrst_wait", 32'(bus_wait), 32'd0);
        check("midrst_oe_n", 32'(sram_oe_n), 32'd1);
        repeat (2) tick();
        reset_n = 1'b1;
        drive(20'h00400, 1'b0, 8'h00); expect_rd("post_rst_lo", orig_byte(20'h00400), 1'b1, 1'b0);
        tick(); drive(20'h00401, 1'b0, 8'h00); expect_rd("post_rst_hi", orig_byte(20'h00401), 1'b1, 1'b0);
        check("midrst_no_pulse", 32'(pulse_cnt), 32'(p0));

        // Byte write to odd address, read back two cycles later
        tick(); drive(20'h00101, 1'b1, 8'h5A); p0 = pulse_cnt;
        tick(); drive(20'h00000, 1'b0, 8'h00);
        #4;
        check("wr_ub_n",  32'(sram_ub_n), 32'd0);
        check("wr_lb_n",  32'(sram_lb_n), 32'd1);
        check("wr_addr",  32'(sram_addr), 32'h00080);
        check("wr_oe_n",  32'(sram_oe_n), 32'd1);
        check("wr_dq",    32'(sram_dq), 32'h5A5A);
        check("wr_wait",  32'(bus_wait), 32'd1);
        tick(); drive(20'h00101, 1'b0, 8'h00); expect_rd("wr_rd", 8'h5A, 1'b1, 1'b0);
        check("wr_one_pulse", 32'(pulse_cnt), 32'(p0 + 1));
        tick(); drive(20'h00100, 1'b0, 8'h00); expect_rd("wr_rd_other_lane", orig_byte(20'h00100), 1'b1, 1'b0);

        // Back-to-back bytes
        tick(); drive(20'h02000, 1'b1, 8'h34); p0 = pulse_cnt;
        tick(); drive(20'h02001, 1'b1, 8'h12);
        tick(); drive(20'h00000, 1'b0, 8'h00);
        check("b2b_first_pulse", 32'(pulse_cnt), 32'(p0 + 1));
        tick(); drive(20'h02000, 1'b0, 8'h00); expect_rd("b2b_lo", 8'h34, 1'b1, 1'b0);
        check("b2b_two_pulses", 32'(pulse_cnt), 32'(p0 + 2));
        tick(); drive(20'h02001, 1'b0, 8'h00); expect_rd("b2b_hi", 8'h12, 1'b1, 1'b0);

        // Out of range
        tick(); drive(20'h80000, 1'b1, 8'hAA); p0 = pulse_cnt;
        tick(); drive(20'h80000, 1'b0, 8'h00); expect_rd("oor_rd", OOR_DATA, 1'b1, 1'b0);
        #4 check("oor_not_pending", 32'(sram_oe_n), 32'd0);
        tick(); drive(20'h00000, 1'b0, 8'h00);
        tick();
        check("oor_no_pulse", 32'(pulse_cnt), 32'(p0));

        // Collisions
        tick(); drive(20'h02000, 1'b1, 8'hC7);
        tick(); drive(20'h02000, 1'b0, 8'h00);
`ifdef SRAM_WFWD_EN
        expect_rd("coll_same", 8'hC7, 1'b1, 1'b0);
`else
        expect_rd("coll_same", 8'h00, 1'b0, 1'b1);
`endif
        tick(); drive(20'h02000, 1'b1, 8'h66);
        tick(); drive(20'h03000, 1'b0, 8'h00); expect_rd("coll_other", 8'h00, 1'b0, 1'b1);
        tick(); drive(20'h02000, 1'b0, 8'h00); expect_rd("coll_after", 8'h66, 1'b1, 1'b0);

        // Random back-to-back writes; WE# monitors check every pulse
        p0 = pulse_cnt;
        la = '0;
        ld = '0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            la = {1'b0, 19'($urandom)};
            ld = 8'($urandom);
            drive(la, 1'b1, ld);
        end
        tick(); drive(20'h00000, 1'b0, 8'h00);
        tick(); drive(la, 1'b0, 8'h00); expect_rd("rand_last", ld, 1'b1, 1'b0);
        check("rand_pulses", 32'(pulse_cnt), 32'(p0 + 1000));

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
